// File: rtl/gd_pkg.sv
// gd_pkg: shared fixed-point types, limits and FSM states for the gradient-descent update stage
package gd_pkg;
    localparam int FRACT_BITS = 8;
    localparam logic signed [31:0] Q24_8_MAX = 32'sh7FFFFFFF;
    localparam logic signed [31:0] Q24_8_MIN = 32'sh80000000;
    localparam logic signed [15:0] Q8_8_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q8_8_MIN = 16'sh8000;
    localparam logic signed [15:0] CONV_THRESH = 16'sh0004;
    typedef logic signed [31:0] q24_8_t;
    typedef logic signed [15:0] q8_8_t;
    typedef enum logic [1:0] {IDLE, ACCEPT, PRESENT} gd_upd_state_e;
endpackage

// File: rtl/q24_8_sat_sub.sv
// q24_8_sat_sub: Q24.8 minus sign-extended Q8.8 with saturation to the Q24.8 range
// Ports: i_a minuend Q24.8, i_b subtrahend Q8.8, o_y saturated difference, o_sat saturation occurred
module q24_8_sat_sub
    import gd_pkg::*;
(
    input  logic signed [31:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [31:0] o_y,
    output logic               o_sat
);
    logic [32:0] w_diff;
    assign w_diff = {i_a[31], i_a} - {{17{i_b[15]}}, i_b};
    assign o_sat = w_diff[32] ^ w_diff[31];
    assign o_y = o_sat ? (w_diff[32] ? Q24_8_MIN : Q24_8_MAX) : w_diff[31:0];
endmodule

// File: rtl/gd_param_update.sv
// gd_param_update: per-iteration saturating parameter update (param -= step) with vector handshake and status
// Ports: clk/rst (sync, active-high); init_valid/init_data load params; step_valid/step_ready/step_in/step_ovf/step_unf
// step stream; param_valid/param_ready/param_out vector out; iter_count, sat_flag, converged status.
// Build option: define GD_CONV_DETECT_EN to enable convergence detection (otherwise converged is tied 0).
module gd_param_update
    import gd_pkg::*;
#(
    parameter int DIM = 4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                init_valid,
    input  logic [DIM*32-1:0]   init_data,
    input  logic                step_valid,
    output logic                step_ready,
    input  logic [15:0]         step_in,
    input  logic                step_ovf,
    input  logic                step_unf,
    output logic                param_valid,
    input  logic                param_ready,
    output logic [DIM*32-1:0]   param_out,
    output logic [15:0]         iter_count,
    output logic                sat_flag,
    output logic                converged
);
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    gd_upd_state_e r_state, w_next;
    logic [IW-1:0] r_idx;
    q24_8_t r_param [DIM];
    logic [15:0] r_iter;
    logic r_sat_acc, r_sat;
    q24_8_t w_sub_y;
    logic w_sub_sat, w_hs, w_first, w_last, w_sat_acc, w_release;

    assign step_ready = r_state == ACCEPT;
    assign param_valid = r_state == PRESENT;
    assign w_hs = step_valid & step_ready;
    assign w_release = param_valid & param_ready;
    assign w_first = r_idx == '0;
    assign w_last = r_idx == IW'(DIM - 1);
    // accumulator restarts at the first element of each vector
    assign w_sat_acc = (~w_first & r_sat_acc) | step_ovf | step_unf | w_sub_sat;

    q24_8_sat_sub u_sub (.i_a(r_param[r_idx]), .i_b(step_in), .o_y(w_sub_y), .o_sat(w_sub_sat));

    always_comb begin
        w_next = r_state;
        w_next = init_valid ? ACCEPT : (w_hs && w_last) ? PRESENT : w_release ? ACCEPT : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_iter <= '0;
            r_sat_acc <= 1'b0;
            r_sat <= 1'b0;
            for (int k = 0; k < DIM; k++) r_param[k] <= '0;
        end else begin
            r_state <= w_next;
            if (init_valid) begin
                for (int k = 0; k < DIM; k++) r_param[k] <= init_data[32*k +: 32];
                r_idx <= '0;
                r_iter <= '0;
                r_sat_acc <= 1'b0;
                r_sat <= 1'b0;
            end else begin
                if (w_hs) begin
                    r_param[r_idx] <= w_sub_y;
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                    r_sat_acc <= w_sat_acc;
                    if (w_last) r_sat <= w_sat_acc;
                end
                if (w_release && r_iter != 16'hFFFF) r_iter <= r_iter + 16'd1;
            end
        end
    end

`ifdef GD_CONV_DETECT_EN
    logic r_conv_acc, r_conv, w_conv_acc;
    logic [16:0] w_abs;
    // 17-bit magnitude so that 16'h8000 becomes 32768 and never converges
    assign w_abs = step_in[15] ? 17'd0 - {1'b1, step_in} : {1'b0, step_in};
    assign w_conv_acc = (w_first | r_conv_acc) & (w_abs <= {1'b0, CONV_THRESH});
    always_ff @(posedge clk) begin
        if (rst || init_valid) begin
            r_conv_acc <= 1'b0;
            r_conv <= 1'b0;
        end else if (w_hs) begin
            r_conv_acc <= w_conv_acc;
            if (w_last) r_conv <= w_conv_acc;
        end
    end
    assign converged = r_conv;
`else
    assign converged = 1'b0;
`endif

    for (genvar g = 0; g < DIM; g++) begin : g_out
        assign param_out[32*g +: 32] = r_param[g];
    end
    assign iter_count = r_iter;
    assign sat_flag = r_sat;
endmodule

// File: tb/tb_gd_param_update.sv
// tb_gd_param_update: randomized scoreboard bench for gd_param_update against an arithmetic reference model
module tb_gd_param_update;
    logic clk = 1'b0;
    logic rst, init_valid, step_valid, step_ready, step_ovf, step_unf;
    logic param_valid, param_ready, sat_flag, converged;
    logic [127:0] init_data, param_out;
    logic [15:0] step_in, iter_count;

    always #5 clk = ~clk;

    gd_param_update #(.DIM(4)) dut (
        .clk(clk), .rst(rst), .init_valid(init_valid), .init_data(init_data),
        .step_valid(step_valid), .step_ready(step_ready), .step_in(step_in),
        .step_ovf(step_ovf), .step_unf(step_unf), .param_valid(param_valid),
        .param_ready(param_ready), .param_out(param_out), .iter_count(iter_count),
        .sat_flag(sat_flag), .converged(converged)
    );

    typedef struct {
        logic [127:0] p;
        logic [15:0]  it;
        logic         s;
        logic         c;
    } exp_t;

    localparam longint PMAX = 64'sd2147483647;
    localparam longint PMIN = -64'sd2147483648;

    exp_t q[$];
    exp_t me;
    int cmp = 0;
    int errs = 0;
    longint mp [4];
    int exp_iter = 0;
    bit acc_sat, acc_conv;
    bit hold = 1'b0;
    bit chk_iter = 1'b0;
    logic [15:0] iter_after;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        cmp++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [127:0] pack_model();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = mp[i][31:0];
        return r;
    endfunction

    task automatic set_model(input logic [127:0] d);
        for (int i = 0; i < 4; i++) mp[i] = longint'($signed(d[32*i +: 32]));
        exp_iter = 0;
    endtask

    // reference: plain integer subtraction clipped to the Q24.8 range
    task automatic step_model(input logic [15:0] s, input bit ovf, input bit unf, input int i);
        longint d;
        int a;
        bit clip;
        exp_t e;
        d = mp[i] - longint'($signed(s));
        clip = 1'b0;
        if (d > PMAX) begin d = PMAX; clip = 1'b1; end
        if (d < PMIN) begin d = PMIN; clip = 1'b1; end
        mp[i] = d;
        if (i == 0) begin acc_sat = 1'b0; acc_conv = 1'b1; end
        a = $signed(s);
        if (a < 0) a = -a;
        acc_sat = acc_sat | ovf | unf | clip;
        acc_conv = acc_conv & (a <= 4);
        if (i == 3) begin
            e.p = pack_model();
            e.it = exp_iter[15:0];
            e.s = acc_sat;
`ifdef GD_CONV_DETECT_EN
            e.c = acc_conv;
`else
            e.c = 1'b0;
`endif
            q.push_back(e);
            if (exp_iter < 65535) exp_iter++;
        end
    endtask

    task automatic send_step(input logic [15:0] s, input bit ovf, input bit unf);
        int n = 0;
        step_valid = 1'b1;
        step_in = s;
        step_ovf = ovf;
        step_unf = unf;
        while (!step_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!step_ready) begin
            cmp++;
            errs++;
            $display("FAIL step_handshake_timeout: step_ready=%b required 1", step_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        step_valid = 1'b0;
        step_ovf = 1'b0;
        step_unf = 1'b0;
    endtask

    task automatic run_vector(input logic [63:0] steps, input logic [3:0] ovf, input logic [3:0] unf);
        for (int i = 0; i < 4; i++) begin
            step_model(steps[16*i +: 16], ovf[i], unf[i], i);
            send_step(steps[16*i +: 16], ovf[i], unf[i]);
        end
        check("pv_timing", param_valid, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            cmp++;
            errs++;
            $display("FAIL drain_timeout: %0d vectors outstanding, required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_init(input logic [127:0] d);
        wait_drain();
        init_valid = 1'b1;
        init_data = d;
        @(posedge clk);
        @(negedge clk);
        init_valid = 1'b0;
        set_model(d);
        check("init_param_out", param_out, d);
        check("init_iter", iter_count, 0);
        check("init_pv", param_valid, 0);
        check("init_sat", sat_flag, 0);
        check("init_conv", converged, 0);
        check("init_step_ready", step_ready, 1);
    endtask

    function automatic logic [31:0] rand_param();
        int c;
        c = $urandom_range(0, 3);
        if (c == 0) return 32'h7FFFFF00 + 32'($urandom_range(0, 255));
        if (c == 1) return 32'h80000000 + 32'($urandom_range(0, 255));
        return $urandom;
    endfunction

    initial begin
        param_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            param_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_iter) begin
                chk_iter = 1'b0;
                check("iter_after_release", iter_count, iter_after);
            end
            if (param_valid && param_ready) begin
                if (q.size() == 0) begin
                    cmp++;
                    errs++;
                    $display("FAIL unexpected_vector: param_valid=1 with no vector expected");
                end else begin
                    me = q.pop_front();
                    check("param_out", param_out, me.p);
                    check("iter_count", iter_count, me.it);
                    check("sat_flag", sat_flag, me.s);
                    check("converged", converged, me.c);
                    iter_after = (me.it == 16'hFFFF) ? me.it : me.it + 16'd1;
                    chk_iter = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        rst = 1'b1;
        init_valid = 1'b0;
        init_data = '0;
        step_valid = 1'b0;
        step_in = '0;
        step_ovf = 1'b0;
        step_unf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_param_out", param_out, 0);
        check("rst_step_ready", step_ready, 0);
        check("rst_pv", param_valid, 0);
        check("rst_iter", iter_count, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_conv", converged, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_step_ready", step_ready, 0);

        do_init({4{32'h00000100}});
        run_vector({4{16'h0080}}, 4'b0, 4'b0);

        do_init({32'h0, 32'h0, 32'h0, 32'h7FFFFF00});
        run_vector({16'h0, 16'h0, 16'h0, 16'hFF00}, 4'b0, 4'b0);
        run_vector({16'h0, 16'h0, 16'h0, 16'h0}, 4'b0, 4'b0);

        do_init({32'h0, 32'h0, 32'h0, 32'h00010000});
        run_vector({16'h0, 16'h0, 16'h0, 16'h7FFF}, 4'b0001, 4'b0);

        hold = 1'b1;
        run_vector({$urandom, $urandom}, 4'b0, 4'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_pv", param_valid, 1);
            check("bp_step_ready", step_ready, 0);
            check("bp_param_out", param_out, q[0].p);
            check("bp_iter", iter_count, q[0].it);
            check("bp_sat", sat_flag, q[0].s);
        end
        hold = 1'b0;

        do_init('0);
        run_vector({16'h0003, 16'h0000, 16'hFFFC, 16'h0004}, 4'b0, 4'b0);
        run_vector({16'h0000, 16'h0000, 16'h0000, 16'h0005}, 4'b0, 4'b0);
        run_vector({16'h0000, 16'h0000, 16'h0000, 16'h8000}, 4'b0, 4'b0);
        run_vector({16'hFFFD, 16'h0001, 16'h0002, 16'hFFFF}, 4'b0, 4'b0);

        do_init({32'h00001000, 32'h00002000, 32'h00003000, 32'h00004000});
        step_model(16'h0100, 1'b0, 1'b0, 0);
        send_step(16'h0100, 1'b0, 1'b0);
        step_model(16'h0200, 1'b0, 1'b0, 1);
        send_step(16'h0200, 1'b0, 1'b0);
        do_init({32'h00000500, 32'h00000600, 32'h00000700, 32'h00000800});
        run_vector({16'h0010, 16'h0020, 16'h0030, 16'h0040}, 4'b0, 4'b0);

        repeat (40) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 4; i++) d[32*i +: 32] = rand_param();
                do_init(d);
            end
            if ($urandom_range(0, 9) == 0) begin
                step_model(16'($urandom), 1'b0, 1'b0, 0);
                send_step(step_in, 1'b0, 1'b0);
                for (int i = 0; i < 4; i++) d[32*i +: 32] = rand_param();
                do_init(d);
            end
            run_vector({$urandom, $urandom},
                       4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                       4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
        end

        hold = 1'b0;
        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/gd_param_update.md
# gd_param_update

Sequential parameter-update stage for the 4D gradient-descent datapath. It sits directly downstream of the capped Q8.8 multiplier that produces `lr * grad` step terms. Each iteration it accepts one saturated Q8.8 step per dimension over a valid/ready handshake and subtracts it from the matching Q24.8 parameter with saturation. When the vector is complete it presents the updated parameter vector with saturation and convergence status.

## Interface
- `DIM`, 4, number of parameter dimensions.
- `CONV_THRESH`, 16'sh0004, Q8.8 magnitude threshold for convergence (0.015625).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `init_valid`  in  1  load initial parameters (one-cycle strobe).
- `init_data`  in  DIM*32  initial parameters, Q24.8 signed; element i at [32i+31:32i].
- `step_valid`  in  1  step term valid.
- `step_ready`  out  1  stage accepts a step this cycle.
- `step_in`  in  16  signed Q8.8 step from the multiplier.
- `step_ovf`  in  1  multiplier positive-cap flag for `step_in`.
- `step_unf`  in  1  multiplier negative-cap flag for `step_in`.
- `param_valid`  out  1  updated vector available.
- `param_ready`  in  1  consumer accepts the vector.
- `param_out`  out  DIM*32  current parameters, Q24.8, same packing as `init_data`.
- `iter_count`  out  16  completed iterations, saturating at 16'hFFFF.
- `sat_flag`  out  1  any saturation occurred in the presented vector.
- `converged`  out  1  every |step| in the presented vector was <= `CONV_THRESH`.

## Operation
- FSM states: IDLE, ACCEPT, PRESENT.
  - IDLE: waits for `init_valid`.
  - ACCEPT: index `idx` runs 0..DIM-1; one step is consumed per handshake (`step_valid & step_ready`).
  - PRESENT: holds `param_valid` until `param_ready`, then returns to ACCEPT with `idx=0` and `iter_count+1`.
- `step_ready` is 1 only in ACCEPT and is decoded from registered state.
- Each handshake performs the following:
  - `step_in` is sign-extended to 32 bits; Q8.8 and Q24.8 share 8 fraction bits, so there is no shift.
  - `param[idx]` minus the extended step is computed in 33 bits and saturated to 32'h7FFFFFFF / 32'h80000000.
  - The result is written to `param[idx]`.
- Per-vector status accumulators are cleared on the handshake at `idx=0`.
  - Saturation accumulator: set by `step_ovf`, `step_unf`, or subtraction saturation.
  - Convergence accumulator: ANDs (|step| <= `CONV_THRESH`). |16'h8000| is treated as 32768, so it never converges.
- On the last handshake (`idx=DIM-1`), the accumulators are copied into `sat_flag` and `converged`, and the FSM enters PRESENT.
- `init_valid` has priority in every state:
  - loads all params and clears `iter_count`, `idx`, and status;
  - drops `param_valid` and enters ACCEPT;
  - discards any partial vector.
- `param_out` always reflects the parameter registers. It is guaranteed consistent only while `param_valid` is high.

## Timing
- Reset values: state IDLE, all params 0, `idx` 0, `iter_count` 0, `step_ready` 0, `param_valid` 0, `sat_flag` 0, `converged` 0.
- A parameter register updates at the clock edge of its step handshake.
- `param_valid` rises the cycle after the DIM-th handshake. Best-case throughput is DIM+1 cycles per iteration.
- Backpressure: while `param_valid & ~param_ready`, `param_out`, `sat_flag`, `converged` and `iter_count` are held stable and `step_ready` is 0.
- `iter_count` increments on the `param_valid & param_ready` edge. At 16'hFFFF it holds.
- `init_valid` coinciding with a step handshake: init wins and the step is dropped. The upstream sees `step_ready` high, so the multiplier controller must not strobe init mid-vector unless aborting.
- `rst` mid-operation returns to the reset values on the next edge, with no partial commit.

## Configuration
- `GD_CONV_DETECT_EN` defined: the convergence accumulator and `converged` output behave as above.
- `GD_CONV_DETECT_EN` undefined: the accumulator and comparator are removed and `converged` is tied 0. All other behaviour is unchanged.

## Structure
- Package `gd_pkg` holds the following:
  - `FRACT_BITS=8`;
  - Q24.8 max/min and Q8.8 max/min constants;
  - `q24_8_t` / `q8_8_t` signed typedefs;
  - state enum `gd_upd_state_e`.
- Sub-module `q24_8_sat_sub`: combinational 32-bit minus sign-extended 16-bit saturating subtract with a saturation flag out. It is instantiated once and muxed by `idx`.

## Test plan
- Reset, init all params 32'h00000100, then four steps 16'h0080 → each `param_out` element 32'h00000080; `param_valid` at cycle 5 after the first handshake; `iter_count`=1; `sat_flag`=0.
- Param0 32'h7FFFFF00 with step 16'hFF00 (-1.0) → param0 capped at 32'h7FFFFFFF; `sat_flag`=1. The next clean vector clears `sat_flag` to 0.
- Step 16'h7FFF with `step_ovf`=1 and no subtraction overflow → `sat_flag`=1 and the param decreases by 32'h00007FFF.
- Hold `param_ready` low for 5 cycles in PRESENT → `param_valid` stays 1, `step_ready` stays 0, outputs are stable, `iter_count` is unchanged until the release edge.
- With `GD_CONV_DETECT_EN`:
  - steps {0004,FFFC,0000,0003} → `converged`=1;
  - steps {0005,0,0,0} → 0;
  - steps {8000,0,0,0} → 0.
  - Without the macro → always 0.
- `init_valid` after 2 of 4 handshakes → partial updates are overwritten by `init_data`, `idx`=0, `iter_count`=0, and the next four steps form a fresh vector.
